// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU classes, the decoder control word
// and its bubble value.
package mips_pkg;

    localparam int NBITS_DEF = 32;
    localparam int NREG_DEF  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        ALU_ADD     = 2'b00,
        ALU_SUB     = 2'b01,
        ALU_FUNCT   = 2'b10,
        ALU_INVALID = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    jump;
        logic    branch;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_dst: 1'b0, jump: 1'b0, branch: 1'b0, mem_read: 1'b0,
        mem_to_reg: 1'b0, mem_write: 1'b0, alu_src: 1'b0, reg_write: 1'b0,
        alu_op: ALU_ADD
    };

endpackage

// File: rtl/riesgo_carga.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle stall.
module riesgo_carga
    import mips_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic            i_ExMemRead,
    input  logic            i_ExValid,
    input  logic [NREG-1:0] i_ExRt,
    input  logic [NREG-1:0] i_IdRs,
    input  logic [NREG-1:0] i_IdRt,
    input  logic            i_IdALUSrc,
    input  logic            i_IdMemWrite,
    input  logic            i_Flush,
    output logic            o_Stall,
    output logic            o_Hazard
);

    logic id_reads_rt;
    logic rt_match;

    // Stores read rt as data even though they use the immediate for the ALU.
    assign id_reads_rt = ~i_IdALUSrc | i_IdMemWrite;
    assign rt_match    = (i_ExRt == i_IdRs) | ((i_ExRt == i_IdRt) & id_reads_rt);

    assign o_Hazard = i_ExValid & i_ExMemRead & (i_ExRt != '0) & rt_match;
    assign o_Stall  = o_Hazard & ~i_Flush;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with bubble injection on flush or load-use hazard
// and a debug step enable that freezes the whole stage.
module id_ex_latch
    import mips_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int NREG  = NREG_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Enable,
    input  logic             i_Flush,
    input  logic             i_RegDst,
    input  logic             i_Jump,
    input  logic             i_Branch,
    input  logic             i_MemRead,
    input  logic             i_MemToReg,
    input  logic             i_MemWrite,
    input  logic             i_ALUSrc,
    input  logic             i_RegWrite,
    input  logic [1:0]       i_ALUOp,
    input  logic [NBITS-1:0] i_PC4,
    input  logic [NBITS-1:0] i_Dato1,
    input  logic [NBITS-1:0] i_Dato2,
    input  logic [NBITS-1:0] i_Extension,
    input  logic [NREG-1:0]  i_Rs,
    input  logic [NREG-1:0]  i_Rt,
    input  logic [NREG-1:0]  i_Rd,
    input  logic [5:0]       i_Funct,
    output logic             o_RegDst,
    output logic             o_Jump,
    output logic             o_Branch,
    output logic             o_MemRead,
    output logic             o_MemToReg,
    output logic             o_MemWrite,
    output logic             o_ALUSrc,
    output logic             o_RegWrite,
    output logic [1:0]       o_ALUOp,
    output logic [NBITS-1:0] o_PC4,
    output logic [NBITS-1:0] o_Dato1,
    output logic [NBITS-1:0] o_Dato2,
    output logic [NBITS-1:0] o_Extension,
    output logic [NREG-1:0]  o_Rs,
    output logic [NREG-1:0]  o_Rt,
    output logic [NREG-1:0]  o_Rd,
    output logic [5:0]       o_Funct,
    output logic             o_Valid,
    output logic             o_Stall
);

    typedef struct packed {
        ctrl_t            ctrl;
        logic [NBITS-1:0] pc4;
        logic [NBITS-1:0] dato1;
        logic [NBITS-1:0] dato2;
        logic [NBITS-1:0] ext;
        logic [NREG-1:0]  rs;
        logic [NREG-1:0]  rt;
        logic [NREG-1:0]  rd;
        logic [5:0]       funct;
        logic             valid;
    } stage_t;

    stage_t stage_in;
    stage_t stage_d;
    stage_t stage_q;
    logic   hazard;

    assign stage_in = '{
        ctrl: '{
            reg_dst: i_RegDst, jump: i_Jump, branch: i_Branch,
            mem_read: i_MemRead, mem_to_reg: i_MemToReg,
            mem_write: i_MemWrite, alu_src: i_ALUSrc,
            reg_write: i_RegWrite, alu_op: alu_op_e'(i_ALUOp)
        },
        pc4: i_PC4, dato1: i_Dato1, dato2: i_Dato2, ext: i_Extension,
        rs: i_Rs, rt: i_Rt, rd: i_Rd, funct: i_Funct,
        valid: 1'b1
    };

    riesgo_carga #(.NREG(NREG)) u_riesgo_carga (
        .i_ExMemRead (stage_q.ctrl.mem_read),
        .i_ExValid   (stage_q.valid),
        .i_ExRt      (stage_q.rt),
        .i_IdRs      (i_Rs),
        .i_IdRt      (i_Rt),
        .i_IdALUSrc  (i_ALUSrc),
        .i_IdMemWrite(i_MemWrite),
        .i_Flush     (i_Flush),
        .o_Stall     (o_Stall),
        .o_Hazard    (hazard)
    );

    always_comb begin
        // NOTE: defaulting to the held value first means every path assigns
        // stage_d, so no latch is inferred when i_Enable is low.
        stage_d = stage_q;
        if (i_Enable) begin
            if (i_Flush || hazard) begin
                stage_d      = '0;
                stage_d.ctrl = CTRL_BUBBLE;
            end else begin
                stage_d = stage_in;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (i_reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_RegDst    = stage_q.ctrl.reg_dst;
    assign o_Jump      = stage_q.ctrl.jump;
    assign o_Branch    = stage_q.ctrl.branch;
    assign o_MemRead   = stage_q.ctrl.mem_read;
    assign o_MemToReg  = stage_q.ctrl.mem_to_reg;
    assign o_MemWrite  = stage_q.ctrl.mem_write;
    assign o_ALUSrc    = stage_q.ctrl.alu_src;
    assign o_RegWrite  = stage_q.ctrl.reg_write;
    assign o_ALUOp     = stage_q.ctrl.alu_op;
    assign o_PC4       = stage_q.pc4;
    assign o_Dato1     = stage_q.dato1;
    assign o_Dato2     = stage_q.dato2;
    assign o_Extension = stage_q.ext;
    assign o_Rs        = stage_q.rs;
    assign o_Rt        = stage_q.rt;
    assign o_Rd        = stage_q.rd;
    assign o_Funct     = stage_q.funct;
    assign o_Valid     = stage_q.valid;

endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

Pipeline register between decode (ID) and execute (EX) of the MIPS core. Captures the decoder's control word, the register-file read data, the sign-extended immediate and the register specifiers each cycle. Also contains the load-use hazard detector: it stalls PC and IF/ID and injects a bubble into EX. Also injects a bubble on a control-flow flush, and honours a global step enable from the debug unit.

## Interface
Parameters:
- NBITS, 32, datapath width (PC+4, register data, immediate)
- NREG, 5, register specifier width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high; clears all state
- i_Enable  in  1  debug step enable; 0 freezes the whole register
- i_Flush  in  1  branch/jump taken: the instruction now in ID is discarded
- i_RegDst, i_Jump, i_Branch, i_MemRead, i_MemToReg, i_MemWrite, i_ALUSrc, i_RegWrite  in  1 each  decoder control bits
- i_ALUOp  in  2  decoder ALU class (00 add, 01 sub/compare, 10 R-type funct, 11 invalid)
- i_PC4, i_Dato1, i_Dato2, i_Extension  in  NBITS each  PC+4, rs data, rt data, sign-extended immediate
- i_Rs, i_Rt, i_Rd  in  NREG each  register specifiers
- i_Funct  in  6  instruction[5:0]
- o_RegDst … o_RegWrite, o_ALUOp, o_PC4, o_Dato1, o_Dato2, o_Extension, o_Rs, o_Rt, o_Rd, o_Funct  out  same widths  registered copies
- o_Valid  out  1  EX holds a real instruction (0 = bubble)
- o_Stall  out  1  combinational; hold PC and IF/ID this cycle

## Operation
- Hazard condition: all of:
  - o_Valid=1 and o_MemRead=1
  - o_Rt != 0
  - either o_Rt == i_Rs, or (o_Rt == i_Rt and the ID instruction reads rt: i_ALUSrc=0 or i_MemWrite=1)
- o_Stall = hazard & ~i_Flush. A flushed instruction never stalls.
- Per-edge update, priority highest first:
  1. i_reset: all outputs 0, o_Valid=0 (asynchronous).
  2. i_Enable=0: hold every register.
  3. i_Flush=1: load a bubble.
  4. hazard=1: load a bubble.
  5. Otherwise: load all inputs, o_Valid=1.
- Bubble: every control output 0, o_ALUOp=00, all data/specifier outputs 0, o_Valid=0.
- An invalid opcode (decoder ALUOp=11, all other controls 0) is loaded normally with o_Valid=1. Only the EX stage treats it as a NOP.
- No arithmetic; widths pass through unchanged.

## Timing
- Latency: one cycle, ID input to EX output.
- Load-use: exactly one bubble per hazard. After the bubble, o_MemRead=0, so hazard drops and the stalled instruction loads on the next enabled edge.
- o_Stall reflects current inputs and registered state within the same cycle. It is not gated by i_Enable: while frozen, PC and IF/ID are also frozen by i_Enable.
- Flush and hazard in the same cycle: bubble, o_Stall=0.
- Reset asserted mid-stall: outputs clear immediately. o_Stall falls combinationally because o_Valid=0.
- Reset release: first enabled edge loads ID normally.

## Structure
- Shared package (mips_pkg): opcode constants (LW, SW, BEQ, J, R-type, ADDI), ALUOp encodings, bubble control-word constant, NBITS/NREG defaults.
- Sub-module riesgo_carga: purely combinational hazard compare (o_MemRead, o_Valid, o_Rt, i_Rs, i_Rt, i_ALUSrc, i_MemWrite, i_Flush → o_Stall, hazard).
- Top holds the register bank and priority mux.

## Test plan
- Reset: assert i_reset with random inputs → all outputs 0, o_Valid=0, o_Stall=0, immediately with no clock edge.
- Pass-through: i_Enable=1, ADD with Rs=1, Rt=2, Rd=3, Dato1=5, Dato2=7, ALUOp=10, RegDst=1, RegWrite=1 → next edge outputs equal inputs, o_Valid=1.
- Load-use on rs:
  - Stimulus: LW Rt=4 loaded into EX, then ID presents ADD with Rs=4.
  - Response: o_Stall=1, next edge o_Valid=0 with all controls 0; following edge loads the ADD, o_Stall=0.
- Hazard guard cases:
  - LW Rt=4 followed by ADDI Rs=1, Rt=4 (ALUSrc=1) → no stall.
  - LW Rt=0 followed by ADD Rs=0 → no stall.
  - LW Rt=4 followed by SW Rt=4 → stall.
- Flush with simultaneous hazard: i_Flush=1 while the hazard condition holds → o_Stall=0, next edge bubble, o_Valid=0.
- Enable freeze: load SW (MemWrite=1, Extension=0x10), drop i_Enable for 3 edges while inputs change → outputs unchanged. Raise i_Enable → new inputs captured.
